// File: rtl/intrusion_alarm_ctrl.sv
// Intrusion alarm controller: debounces the encoded zone stream and runs the
// disarmed / exit-delay / armed / entry-delay / alarm sequence.
module intrusion_alarm_ctrl #(
    parameter int          DEBOUNCE   = 4,
    parameter int          EXIT_DLY   = 16,
    parameter int          ENTRY_DLY  = 16,
    parameter logic [2:0]  ENTRY_ZONE = 3'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] intrusion_zone,
    input  logic       valid,
    input  logic       arm,
    input  logic       disarm,
    output logic       siren,
    output logic       armed,
    output logic       chime,
    output logic [2:0] alarm_zone,
    output logic       alarm_zone_vld,
    output logic [7:0] alarm_count
);

    localparam int SW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TMAX = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] EXIT_T   = TW'(EXIT_DLY - 1);
    localparam logic [TW-1:0] ENTRY_T  = TW'(ENTRY_DLY - 1);

    typedef enum logic [2:0] {
        S_DISARMED,
        S_EXIT,
        S_ARMED,
        S_ENTRY,
        S_ALARM
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    logic [3:0]    sample;
    logic [3:0]    prev_sample;
    logic [SW-1:0] stab_cnt;
    logic          same;
    logic          det;

    assign sample = {valid, intrusion_zone};
    assign same   = (sample == prev_sample);
    // The live match term drops det the moment the zone changes, so a stale
    // saturated count can never qualify a new zone.
    assign det    = valid && same && (stab_cnt == STAB_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block sees pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample <= '0;
            stab_cnt    <= '0;
        end else begin
            prev_sample <= sample;
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + SW'(1);
        end
    end

    // {siren, armed, chime} for a given state; outputs are loaded together
    // with the state so they change on the same edge.
    function automatic logic [2:0] decode(input state_t s);
        case (s)
            S_EXIT:  decode = 3'b001;
            S_ARMED: decode = 3'b010;
            S_ENTRY: decode = 3'b011;
            S_ALARM: decode = 3'b110;
            default: decode = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_DISARMED;
            timer          <= '0;
            siren          <= 1'b0;
            armed          <= 1'b0;
            chime          <= 1'b0;
            alarm_zone     <= '0;
            alarm_zone_vld <= 1'b0;
            alarm_count    <= '0;
        end else if (disarm && state != S_DISARMED) begin
            state                 <= S_DISARMED;
            {siren, armed, chime} <= decode(S_DISARMED);
        end else begin
            case (state)
                S_DISARMED: begin
                    if (arm && !disarm) begin
                        state                 <= S_EXIT;
                        {siren, armed, chime} <= decode(S_EXIT);
                        timer                 <= EXIT_T;
                        alarm_zone            <= '0;
                        alarm_zone_vld        <= 1'b0;
                    end
                end
                S_EXIT: begin
                    if (timer == '0) begin
                        state                 <= S_ARMED;
                        {siren, armed, chime} <= decode(S_ARMED);
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_ARMED: begin
                    if (det) begin
                        alarm_zone     <= intrusion_zone;
                        alarm_zone_vld <= 1'b1;
                        if (intrusion_zone == ENTRY_ZONE) begin
                            state                 <= S_ENTRY;
                            {siren, armed, chime} <= decode(S_ENTRY);
                            timer                 <= ENTRY_T;
                        end else begin
                            state                 <= S_ALARM;
                            {siren, armed, chime} <= decode(S_ALARM);
                            if (alarm_count != 8'hFF)
                                alarm_count <= alarm_count + 8'd1;
                        end
                    end
                end
                S_ENTRY: begin
                    // A non-entry zone escalates immediately and takes over the
                    // latched zone, even when the grace timer expires this cycle.
                    if (det && intrusion_zone != ENTRY_ZONE) begin
                        state                 <= S_ALARM;
                        {siren, armed, chime} <= decode(S_ALARM);
                        alarm_zone            <= intrusion_zone;
                        if (alarm_count != 8'hFF)
                            alarm_count <= alarm_count + 8'd1;
                    end else if (timer == '0) begin
                        state                 <= S_ALARM;
                        {siren, armed, chime} <= decode(S_ALARM);
                        if (alarm_count != 8'hFF)
                            alarm_count <= alarm_count + 8'd1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_ALARM: begin
                    state <= S_ALARM;
                end
                default: begin
                    state                 <= S_DISARMED;
                    {siren, armed, chime} <= decode(S_DISARMED);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intrusion_alarm_ctrl.sv
// Bench for intrusion_alarm_ctrl: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_intrusion_alarm_ctrl;

    localparam int         DEBOUNCE   = 4;
    localparam int         EXIT_DLY   = 16;
    localparam int         ENTRY_DLY  = 16;
    localparam logic [2:0] ENTRY_ZONE = 3'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] intrusion_zone = '0;
    logic       valid = 1'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       siren;
    logic       armed;
    logic       chime;
    logic [2:0] alarm_zone;
    logic       alarm_zone_vld;
    logic [7:0] alarm_count;

    int n_cmp = 0;
    int n_err = 0;

    intrusion_alarm_ctrl #(
        .DEBOUNCE   (DEBOUNCE),
        .EXIT_DLY   (EXIT_DLY),
        .ENTRY_DLY  (ENTRY_DLY),
        .ENTRY_ZONE (ENTRY_ZONE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .intrusion_zone (intrusion_zone),
        .valid          (valid),
        .arm            (arm),
        .disarm         (disarm),
        .siren          (siren),
        .armed          (armed),
        .chime          (chime),
        .alarm_zone     (alarm_zone),
        .alarm_zone_vld (alarm_zone_vld),
        .alarm_count    (alarm_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {P_OFF, P_EXIT, P_ARMED, P_ENTRY, P_ALARM} phase_e;

    phase_e     m_phase;
    int         m_since;
    logic [2:0] m_zone;
    logic       m_zvld;
    int         m_count;
    logic [3:0] m_hist [DEBOUNCE];

    task automatic model_reset();
        m_phase = P_OFF;
        m_since = 0;
        m_zone  = '0;
        m_zvld  = 1'b0;
        m_count = 0;
        for (int i = 0; i < DEBOUNCE; i++) m_hist[i] = '0;
    endtask

    task automatic model_alarm();
        m_phase = P_ALARM;
        if (m_count < 255) m_count = m_count + 1;
    endtask

    // A detection needs the current input to match each of the last DEBOUNCE
    // sampled inputs, with valid high.
    task automatic model_step();
        logic [3:0] cur;
        logic       det;
        cur = {valid, intrusion_zone};
        det = valid;
        for (int i = 0; i < DEBOUNCE; i++)
            if (m_hist[i] != cur) det = 1'b0;
        for (int i = 0; i < DEBOUNCE - 1; i++) m_hist[i] = m_hist[i+1];
        m_hist[DEBOUNCE-1] = cur;
        m_since = m_since + 1;

        if (m_phase != P_OFF && disarm) begin
            m_phase = P_OFF;
        end else begin
            case (m_phase)
                P_OFF: if (arm && !disarm) begin
                    m_phase = P_EXIT;
                    m_since = 0;
                    m_zone  = '0;
                    m_zvld  = 1'b0;
                end
                P_EXIT: if (m_since == EXIT_DLY) m_phase = P_ARMED;
                P_ARMED: if (det) begin
                    m_zone = intrusion_zone;
                    m_zvld = 1'b1;
                    if (intrusion_zone == ENTRY_ZONE) begin
                        m_phase = P_ENTRY;
                        m_since = 0;
                    end else begin
                        model_alarm();
                    end
                end
                P_ENTRY: begin
                    if (det && intrusion_zone != ENTRY_ZONE) begin
                        m_zone = intrusion_zone;
                        model_alarm();
                    end else if (m_since == ENTRY_DLY) begin
                        model_alarm();
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [14:0] model_outs();
        logic s, a, c;
        s = (m_phase == P_ALARM);
        a = (m_phase == P_ARMED) || (m_phase == P_ENTRY) || (m_phase == P_ALARM);
        c = (m_phase == P_EXIT) || (m_phase == P_ENTRY);
        return {s, a, c, m_zone, m_zvld, m_count[7:0]};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic [14:0] dut_o, exp_o;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                dut_o = {siren, armed, chime, alarm_zone, alarm_zone_vld, alarm_count};
                exp_o = model_outs();
                n_cmp++;
                if (dut_o !== exp_o) begin
                    n_err++;
                    $display("FAIL model_cmp t=%0t: dut s/a/c=%b%b%b zone=%0d vld=%b cnt=%0d, model s/a/c=%b%b%b zone=%0d vld=%b cnt=%0d",
                             $time, dut_o[14], dut_o[13], dut_o[12], dut_o[11:9], dut_o[8], dut_o[7:0],
                             exp_o[14], exp_o[13], exp_o[12], exp_o[11:9], exp_o[8], exp_o[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        cycles(1);
        arm = 1'b0;
    endtask

    task automatic disarm_pulse();
        disarm = 1'b1;
        cycles(1);
        disarm = 1'b0;
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;
        check("reset_siren", {7'd0, siren}, 8'd0);
        check("reset_armed", {7'd0, armed}, 8'd0);
        check("reset_chime", {7'd0, chime}, 8'd0);
        check("reset_vld",   {7'd0, alarm_zone_vld}, 8'd0);
        check("reset_count", alarm_count, 8'd0);

        // Exit delay: 16 cycles of chime before armed.
        arm_pulse();
        check("exit_chime_first", {7'd0, chime}, 8'd1);
        check("exit_armed_first", {7'd0, armed}, 8'd0);
        cycles(15);
        check("exit_chime_last", {7'd0, chime}, 8'd1);
        check("exit_armed_last", {7'd0, armed}, 8'd0);
        cycles(1);
        check("armed_after_exit", {6'd0, armed, chime}, 8'b10);

        // Entry grace expiry on zone 0.
        valid = 1'b1; intrusion_zone = 3'd0;
        cycles(4);
        check("entry_not_yet", {7'd0, chime}, 8'd0);
        cycles(1);
        check("entry_chime", {7'd0, chime}, 8'd1);
        check("entry_zone", {5'd0, alarm_zone}, 8'd0);
        check("entry_vld", {7'd0, alarm_zone_vld}, 8'd1);
        cycles(15);
        check("entry_no_siren_yet", {7'd0, siren}, 8'd0);
        cycles(1);
        check("entry_expired_siren", {7'd0, siren}, 8'd1);
        check("entry_expired_count", alarm_count, 8'd1);
        valid = 1'b0;
        disarm_pulse();
        check("disarm_siren_off", {6'd0, siren, armed}, 8'd0);
        check("zone_vld_retained", {7'd0, alarm_zone_vld}, 8'd1);

        // Immediate alarm on zone 5, then asynchronous reset inside ALARM.
        arm_pulse();
        check("rearm_vld_cleared", {7'd0, alarm_zone_vld}, 8'd0);
        cycles(16);
        valid = 1'b1; intrusion_zone = 3'd5;
        cycles(5);
        check("immediate_siren", {7'd0, siren}, 8'd1);
        check("immediate_zone", {5'd0, alarm_zone}, 8'd5);
        check("immediate_count", alarm_count, 8'd2);
        valid = 1'b0; intrusion_zone = 3'd0;
        rst_n = 1'b0;
        #1;
        check("async_rst_siren", {7'd0, siren}, 8'd0);
        check("async_rst_armed", {7'd0, armed}, 8'd0);
        check("async_rst_count", alarm_count, 8'd0);
        check("async_rst_vld", {7'd0, alarm_zone_vld}, 8'd0);
        cycles(2);
        rst_n = 1'b1;

        // Glitch rejection: zone 2 present for only 3 samples.
        arm_pulse();
        cycles(16);
        valid = 1'b1; intrusion_zone = 3'd2;
        cycles(3);
        valid = 1'b0; intrusion_zone = 3'd0;
        cycles(6);
        check("glitch_armed", {6'd0, armed, siren}, 8'b10);
        check("glitch_chime", {7'd0, chime}, 8'd0);

        // Disarm in the last cycle of the entry delay.
        valid = 1'b1;
        cycles(5);
        check("entry2_chime", {7'd0, chime}, 8'd1);
        cycles(15);
        disarm = 1'b1;
        cycles(1);
        disarm = 1'b0; valid = 1'b0;
        check("disarm_at_expiry", {5'd0, siren, armed, chime}, 8'd0);
        check("disarm_at_expiry_cnt", alarm_count, 8'd0);

        // arm and disarm together keep the system disarmed.
        arm = 1'b1; disarm = 1'b1;
        cycles(1);
        arm = 1'b0; disarm = 1'b0;
        check("arm_and_disarm", {6'd0, armed, chime}, 8'd0);

        // Escalation from ENTRY on zone 6.
        arm_pulse();
        cycles(16);
        valid = 1'b1; intrusion_zone = 3'd0;
        cycles(5);
        intrusion_zone = 3'd6;
        cycles(5);
        check("escalate_siren", {7'd0, siren}, 8'd1);
        check("escalate_zone", {5'd0, alarm_zone}, 8'd6);
        check("escalate_count", alarm_count, 8'd1);
        valid = 1'b0; intrusion_zone = 3'd0;
        disarm_pulse();

        // Non-entry detection lands on the same edge the grace timer expires.
        arm_pulse();
        cycles(16);
        valid = 1'b1; intrusion_zone = 3'd0;
        cycles(5);
        cycles(11);
        intrusion_zone = 3'd7;
        cycles(4);
        check("tie_pre_siren", {7'd0, siren}, 8'd0);
        cycles(1);
        check("tie_siren", {7'd0, siren}, 8'd1);
        check("tie_zone", {5'd0, alarm_zone}, 8'd7);
        check("tie_count", alarm_count, 8'd2);
        valid = 1'b0; intrusion_zone = 3'd0;
        disarm_pulse();

        // Saturation of the alarm counter.
        for (int i = 0; i < 260; i++) begin
            arm_pulse();
            cycles(16);
            valid = 1'b1; intrusion_zone = 3'd5;
            cycles(5);
            valid = 1'b0; intrusion_zone = 3'd0;
            disarm_pulse();
        end
        check("count_saturated", alarm_count, 8'd255);
        check("sat_siren_off", {7'd0, siren}, 8'd0);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
